// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// strobe width and the request legality rule.
package lsu_pkg;

    localparam int unsigned STRB_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Exactly one of read/write, a size code valid for the direction, natural alignment.
    function automatic logic req_legal(input logic       rd,
                                       input logic       wr,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = (rd != wr);
        if (wr) begin
            ok = ok && (f3 inside {F3_B, F3_H, F3_W});
        end else begin
            ok = ok && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        if ((f3[1:0] == 2'b01) && addr_lo[0]) begin
            ok = 1'b0;
        end
        if ((f3[1:0] == 2'b10) && (addr_lo != 2'b00)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between right-aligned CPU data and the 32-bit word bus:
// store strobes/replication and load extraction/extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic              i_we,
    input  logic [31:0]       i_wdata,
    input  logic [31:0]       i_rdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [31:0]       o_wdata,
    output logic [31:0]       o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wstrb = '0;
        o_wdata = i_wdata;
        if (i_we) begin
            case (i_funct3)
                F3_B: begin
                    o_wstrb = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                F3_W: begin
                    o_wstrb = 4'b1111;
                    o_wdata = i_wdata;
                end
                default: begin
                    o_wstrb = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_W:    o_rdata = i_rdata;
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a CPU request port to a
// word-organised memory bus, with misalignment checks and an ack timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_memRead,
    input  logic              cpu_memWrite,
    input  logic [2:0]        cpu_funct3,
    input  logic [31:0]       cpu_address,
    input  logic [31:0]       cpu_writeData,
    output logic              cpu_done,
    output logic [31:0]       cpu_readData,
    output logic              cpu_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       r_state;
    lsu_state_t       w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_error;

    logic             w_accept;
    logic             w_legal;
    logic             w_bus;
    logic             w_timeout;
    logic [31:0]      w_ld_data;

    assign w_accept  = cpu_valid && (r_state == ST_IDLE);
    assign w_legal   = req_legal(cpu_memRead, cpu_memWrite, cpu_funct3, cpu_address[1:0]);
    assign w_bus     = (r_state == ST_BUS);
    assign w_timeout = w_bus && !mem_ack && (r_count == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_valid) begin
                    w_next = w_legal ? ST_BUS : ST_DONE;
                end
            end
            ST_BUS: begin
                if (mem_ack || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        cpu_ready = (r_state == ST_IDLE);
        mem_req   = (r_state == ST_BUS);
        cpu_done  = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_bus && !mem_ack) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= '0;
        end
    end

    // Bus-facing write enable only set for legal stores so strobes stay 0000 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else if (w_accept) begin
            r_we     <= cpu_memWrite && w_legal;
            r_funct3 <= cpu_funct3;
            r_addr   <= cpu_address;
            r_wdata  <= cpu_writeData;
            if (!w_legal) begin
                r_error <= 1'b1;
                r_rdata <= '0;
            end
        end else if (w_bus) begin
            if (mem_ack) begin
                r_error <= 1'b0;
                r_rdata <= r_we ? '0 : w_ld_data;
            end else if (w_timeout) begin
                r_error <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

    lsu_lane_align u_lane (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_we      (r_we),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata),
        .o_wstrb   (mem_wstrb),
        .o_wdata   (mem_wdata),
        .o_rdata   (w_ld_data)
    );

    assign mem_we       = r_we;
    assign mem_addr     = {r_addr[31:2], 2'b00};
    assign cpu_readData = r_rdata;
    assign cpu_error    = r_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic
// reference model of lane steering, legality, latency and timeout.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_valid = 1'b0;
    logic        cpu_ready;
    logic        cpu_memRead = 1'b0;
    logic        cpu_memWrite = 1'b0;
    logic [2:0]  cpu_funct3 = '0;
    logic [31:0] cpu_address = '0;
    logic [31:0] cpu_writeData = '0;
    logic        cpu_done;
    logic [31:0] cpu_readData;
    logic        cpu_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_valid     (cpu_valid),
        .cpu_ready     (cpu_ready),
        .cpu_memRead   (cpu_memRead),
        .cpu_memWrite  (cpu_memWrite),
        .cpu_funct3    (cpu_funct3),
        .cpu_address   (cpu_address),
        .cpu_writeData (cpu_writeData),
        .cpu_done      (cpu_done),
        .cpu_readData  (cpu_readData),
        .cpu_error     (cpu_error),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a);
        int unsigned lo;
        if (rd == wr) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        lo = 32'(a[1:0]);
        return (lo % m_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = m_size(f3);
        return ((32'd1 << sz) - 32'd1) << a[1:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return 32'(wd[7:0]) * 32'h0101_0101;
            2:       return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        int unsigned sz;
        longint      v;
        sz = m_size(f3);
        if (sz == 4) return rdata;
        v = longint'(rdata >> (8 * a[1:0])) & ((64'd1 << (8 * sz)) - 1);
        if (!f3[2] && v[8*sz-1]) v = v - (64'sd1 <<< (8 * sz));
        return v[31:0];
    endfunction

    // One full request: drive, serve the bus with an ack after `delay` BUS cycles
    // (none if delay >= TO), and check bus fields, latency and result.
    task automatic run_req(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int unsigned delay,
                           input bit spurious);
        bit          legal;
        bit          got_done;
        bit          exp_err;
        int unsigned cyc, req_cycles, done_cyc, exp_done, exp_req;
        logic [31:0] exp_rd;

        legal = m_legal(rd, wr, f3, addr);
        if (!legal) begin
            exp_done = 1; exp_req = 0; exp_err = 1'b1; exp_rd = '0;
        end else if (delay < TO) begin
            exp_done = delay + 2; exp_req = delay + 1; exp_err = 1'b0;
            exp_rd = wr ? 32'd0 : m_load(f3, addr, rdata);
        end else begin
            exp_done = TO + 1; exp_req = TO; exp_err = 1'b1; exp_rd = '0;
        end

        @(negedge clk);
        check_val("ready_idle", 32'(cpu_ready), 32'd1);
        cpu_valid     = 1'b1;
        cpu_memRead   = rd;
        cpu_memWrite  = wr;
        cpu_funct3    = f3;
        cpu_address   = addr;
        cpu_writeData = wd;
        @(posedge clk); #1;
        cpu_valid = 1'b0;

        cyc = 1; req_cycles = 0; got_done = 1'b0; done_cyc = 0;
        while (!got_done && cyc <= 40) begin
            if (cpu_done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end else begin
                if (mem_req) begin
                    req_cycles++;
                    check_val("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    check_val("mem_we", 32'(mem_we), 32'(wr));
                    check_val("mem_wstrb", 32'(mem_wstrb), wr ? m_strb(f3, addr) : 32'd0);
                    if (wr) check_val("mem_wdata", mem_wdata, m_wdata(f3, wd));
                    mem_ack   = (req_cycles - 1 == delay);
                    mem_rdata = mem_ack ? rdata : $urandom();
                    cpu_valid     = 1'($urandom_range(0, 1));
                    cpu_memRead   = 1'($urandom_range(0, 1));
                    cpu_memWrite  = ~cpu_memRead;
                    cpu_address   = $urandom() & 32'hFFFF_FFFC;
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                cpu_valid = 1'b0;
                cyc++;
            end
        end
        check_val("done_seen", 32'(got_done), 32'd1);
        check_val("done_latency", done_cyc, exp_done);
        check_val("req_cycles", req_cycles, exp_req);
        check_val("cpu_error", 32'(cpu_error), 32'(exp_err));
        check_val("cpu_readData", cpu_readData, exp_rd);

        @(posedge clk); #1;
        check_val("done_pulse", 32'(cpu_done), 32'd0);
        check_val("ready_after", 32'(cpu_ready), 32'd1);
        check_val("rdata_hold", cpu_readData, exp_rd);

        if (spurious) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom();
            @(posedge clk); #1;
            mem_ack = 1'b0;
            check_val("spur_ready", 32'(cpu_ready), 32'd1);
            check_val("spur_done", 32'(cpu_done), 32'd0);
            check_val("spur_req", 32'(mem_req), 32'd0);
            check_val("spur_hold", cpu_readData, exp_rd);
            check_val("spur_err_hold", 32'(cpu_error), 32'(exp_err));
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        int unsigned op;
        bit          rd, wr;

        #1 rst_n = 1'b0;
        #11;
        check_val("rst_ready", 32'(cpu_ready), 32'd1);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_done", 32'(cpu_done), 32'd0);
        check_val("rst_err", 32'(cpu_error), 32'd0);
        check_val("rst_rdata", cpu_readData, 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        check_val("rst_wdata", mem_wdata, 32'd0);
        check_val("rst_wstrb", 32'(mem_wstrb), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Directed cases
        run_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        run_req(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0, 0, 1'b0);
        run_req(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hA500_0000, 0, 1'b0);
        check_val("dir_lb", cpu_readData, 32'hFFFF_FFA5);
        run_req(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'hA500_0000, 0, 1'b0);
        check_val("dir_lbu", cpu_readData, 32'h0000_00A5);
        run_req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 32'h8001_1234, 0, 1'b0);
        check_val("dir_lh", cpu_readData, 32'hFFFF_8001);
        run_req(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 32'h8001_1234, 0, 1'b0);
        check_val("dir_lhu", cpu_readData, 32'h0000_8001);
        run_req(1'b1, 1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 0, 1'b0);
        check_val("dir_lw_mis", 32'(cpu_error), 32'd1);
        run_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h5555_5555, 99, 1'b1);
        check_val("dir_timeout", 32'(cpu_error), 32'd1);

        // Reset in the middle of a stalled read
        @(negedge clk);
        cpu_valid = 1'b1; cpu_memRead = 1'b1; cpu_memWrite = 1'b0;
        cpu_funct3 = 3'b010; cpu_address = 32'h80;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        check_val("rstbus_req_on", 32'(mem_req), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("rstbus_req_off", 32'(mem_req), 32'd0);
        check_val("rstbus_done", 32'(cpu_done), 32'd0);
        check_val("rstbus_ready", 32'(cpu_ready), 32'd1);
        @(posedge clk); #1;
        check_val("rstbus_done2", 32'(cpu_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check_val("rstbus_late_ack", 32'(cpu_done), 32'd0);
        check_val("rstbus_late_req", 32'(mem_req), 32'd0);
        run_req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h1234_5678, 0, 1'b0);
        check_val("rstbus_lw", cpu_readData, 32'h1234_5678);

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                rd = 1'($urandom_range(0, 1));
                wr = rd;
            end else begin
                rd = (op > 5);
                wr = !rd;
            end
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            addr = $urandom();
            if ($urandom_range(0, 4) != 0) addr = addr & ~(m_size(f3) - 1);
            run_req(rd, wr, f3, addr, $urandom(), $urandom(),
                    $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
